sevenseg_scan_ctrl: RTL
=======================

SEVENSEG_SCAN_CTRL -- requirements
Module: sevenseg_scan_ctrl

Interface
REQ-001 Parameter PRESCALE, default 16'd1000, clock cycles a digit is lit per slot (legal range 1..65535).
REQ-002 Parameter BLANK_CYC, default 16'd50, all-off clock cycles before each digit slot, for anti-ghosting (legal range 1..65535).
REQ-003 clk  input  1  single system clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 load  input  1  one-cycle strobe; captures load_data into the shadow register.
REQ-006 load_data  input  16  four BCD digits: [15:12] digit 3 (most significant) down to [3:0] digit 0.
REQ-007 lz_suppress  input  1  when high, blank leading zero digits; sampled every cycle.
REQ-008 bcd_out  output  4  BCD code to the shared low-active seven-segment decoder; 4'hF means blank.
REQ-009 digit_en_n  output  4  active-low digit common enables; bit i drives digit i.
REQ-010 pending  output  1  high while the shadow register holds a value not yet applied.
REQ-011 frame_start  output  1  one-cycle pulse at the start of each refresh frame.

Function
REQ-012 Block SHALL time-multiplex one decoder across 4 digits via an FSM with states BLANK and SHOW, a 2-bit digit index and a 16-bit slot counter.
REQ-013 BLANK SHALL last exactly BLANK_CYC cycles, then go to SHOW with the same index and the counter cleared.
REQ-014 SHOW SHALL last exactly PRESCALE cycles, then go to BLANK with index+1 (3 wraps to 0) and the counter cleared.
REQ-015 Frame length SHALL be 4*(BLANK_CYC+PRESCALE) cycles, order digit 0,1,2,3.
REQ-016 All outputs SHALL be registered Moore outputs, consistent with the current state and index, with no combinational input-to-output path.
REQ-017 In BLANK: digit_en_n=4'hF and bcd_out=4'hF.
REQ-018 In SHOW for index i: digit_en_n has only bit i low; bcd_out is active register nibble i, or 4'hF if suppressed.
REQ-019 Active register nibbles with values 10..15 SHALL pass through unchanged; the decoder blanks them.
REQ-020 Leading-zero suppression: with lz_suppress=1, digit i (i=1..3) is suppressed iff nibbles i..3 of the active register are all zero.
REQ-021 Digit 0 SHALL never be suppressed.
REQ-022 load=1 SHALL write load_data to shadow and set pending=1.
REQ-023 A load while pending=1 SHALL overwrite shadow; pending stays 1; the earlier value is discarded.
REQ-024 Frame boundary is the transition from SHOW of digit 3 to BLANK of digit 0.
REQ-025 At a frame boundary with pending=1, shadow SHALL be copied to the active register and pending cleared, so no frame mixes two values.
REQ-026 If load coincides with the boundary cycle, the new load_data SHALL go directly to active and pending SHALL end at 0.
REQ-027 frame_start SHALL be high for exactly the first BLANK cycle of digit 0 after each frame boundary, and not after reset.

Reset
REQ-028 reset=1 SHALL force immediately, regardless of clk: state BLANK, index 0, counter 0, shadow=16'h0, active=16'h0, pending=0, frame_start=0, bcd_out=4'hF, digit_en_n=4'hF.
REQ-029 Reset during any state, including mid-SHOW or a boundary cycle, SHALL abandon the frame and discard any pending load.
REQ-030 After reset release, the first BLANK slot SHALL last the full BLANK_CYC cycles counted from the first rising edge.

Verification (PRESCALE=4, BLANK_CYC=1, frame=20 cycles)
REQ-031 Reset then idle -> bcd_out=4'hF, digit_en_n=4'hF for 1 cycle, then digit_en_n=4'b1110 with bcd_out=0 for 4 cycles; per-digit enables cycle 1110,1101,1011,0111; frame_start every 20 cycles.
REQ-032 load 16'h1234 at cycle 3 -> pending=1 until the boundary; next frame shows bcd 4,3,2,1 on digits 0..3; pending=0.
REQ-033 load 16'h1111 at cycle 5, then 16'h2222 at cycle 9 -> next frame shows only 2 on all digits; 1 never displayed.
REQ-034 lz_suppress=1, active 16'h0050 -> digits 3,2 bcd_out=4'hF with enable low; digit 1=5, digit 0=0; active 16'h0000 -> digits 3..1=4'hF, digit 0=0.
REQ-035 load 16'h9876 on the boundary cycle -> the frame starting then shows 6,7,8,9; pending never observed high.
REQ-036 Assert reset during SHOW of digit 2 with pending=1 -> outputs go to 4'hF/4'hF without a clock edge; after release, display shows 0 and pending=0.

Source files
------------

// File: rtl/sevenseg_scan_ctrl.sv
// sevenseg_scan_ctrl
// -------------------
// Drives four multiplexed seven-segment digits through one shared decoder.
// The controller scans digit 0, 1, 2, 3 in that order. Before each digit is
// lit there is an all-off slot of BLANK_CYC cycles, which prevents ghosting.
// Each digit is then lit for PRESCALE cycles.
//
// A new display value is loaded into a shadow register at any time. It is
// copied into the active register only at a frame boundary, so one frame
// never shows a mix of two values.
//
// Parameters
//   PRESCALE   cycles each digit is lit per slot (1..65535)
//   BLANK_CYC  all-off cycles before each digit slot (1..65535)
//
// Ports
//   clk          system clock, rising edge
//   reset        asynchronous active-high reset
//   load         one-cycle strobe capturing load_data into the shadow register
//   load_data    four BCD digits, [15:12] = digit 3 ... [3:0] = digit 0
//   lz_suppress  blank leading zero digits when high
//   bcd_out      code for the shared decoder, 4'hF = blank
//   digit_en_n   active-low digit enables, bit i = digit i
//   pending      shadow register holds a value not yet shown
//   frame_start  one-cycle pulse in the first blank cycle of each new frame
module sevenseg_scan_ctrl #(
    parameter logic [15:0] PRESCALE  = 16'd1000,
    parameter logic [15:0] BLANK_CYC = 16'd50
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [15:0] load_data,
    input  logic        lz_suppress,
    output logic [3:0]  bcd_out,
    output logic [3:0]  digit_en_n,
    output logic        pending,
    output logic        frame_start
);

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } state_t;

    state_t      state_q,       state_d;
    logic [1:0]  idx_q,         idx_d;
    logic [15:0] cnt_q,         cnt_d;
    logic [15:0] shadow_q,      shadow_d;
    logic [15:0] active_q,      active_d;
    logic        pending_q,     pending_d;
    logic        frame_start_q, frame_start_d;
    logic [3:0]  bcd_out_q,     bcd_out_d;
    logic [3:0]  digit_en_n_q,  digit_en_n_d;
    logic        boundary;

    // Nibble i of the display value. Codes 10..15 are passed through
    // unchanged; the downstream decoder treats them as blank.
    function automatic logic [3:0] nibble_sel(input logic [15:0] value,
                                              input logic [1:0]  idx);
        logic [3:0] nib;
        case (idx)
            2'd0:    nib = value[3:0];
            2'd1:    nib = value[7:4];
            2'd2:    nib = value[11:8];
            default: nib = value[15:12];
        endcase
        return nib;
    endfunction

    // A digit is a leading zero when it and every more significant nibble
    // are zero. Digit 0 is always shown, so a zero value still reads "0".
    function automatic logic lz_blank(input logic [15:0] value,
                                      input logic [1:0]  idx);
        logic blank;
        case (idx)
            2'd1:    blank = (value[15:4]  == 12'h000);
            2'd2:    blank = (value[15:8]  == 8'h00);
            2'd3:    blank = (value[15:12] == 4'h0);
            default: blank = 1'b0;
        endcase
        return blank;
    endfunction

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        cnt_d         = cnt_q + 16'd1;
        shadow_d      = shadow_q;
        active_d      = active_q;
        pending_d     = pending_q;
        frame_start_d = 1'b0;
        boundary      = 1'b0;
        bcd_out_d     = 4'hF;
        digit_en_n_d  = 4'hF;

        case (state_q)
            BLANK: begin
                if (cnt_q == BLANK_CYC - 16'd1) begin
                    state_d = SHOW;
                    cnt_d   = 16'd0;
                end
            end
            default: begin
                if (cnt_q == PRESCALE - 16'd1) begin
                    state_d  = BLANK;
                    idx_d    = idx_q + 2'd1;
                    cnt_d    = 16'd0;
                    boundary = (idx_q == 2'd3);
                end
            end
        endcase

        if (load) begin
            shadow_d  = load_data;
            pending_d = 1'b1;
        end

        // At the frame boundary, a load in the same cycle takes priority
        // over an older shadow value. Either way, nothing is left pending.
        if (boundary) begin
            frame_start_d = 1'b1;
            pending_d     = 1'b0;
            if (load) begin
                active_d = load_data;
            end else if (pending_q) begin
                active_d = shadow_q;
            end
        end

        // Outputs are derived from the next state, so the registered
        // outputs always match the registered state they appear with.
        if (state_d == SHOW) begin
            digit_en_n_d = ~(4'b0001 << idx_d);
            if (lz_suppress && lz_blank(active_d, idx_d)) begin
                bcd_out_d = 4'hF;
            end else begin
                bcd_out_d = nibble_sel(active_d, idx_d);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= BLANK;
            idx_q         <= 2'd0;
            cnt_q         <= 16'd0;
            shadow_q      <= 16'h0000;
            active_q      <= 16'h0000;
            pending_q     <= 1'b0;
            frame_start_q <= 1'b0;
            bcd_out_q     <= 4'hF;
            digit_en_n_q  <= 4'hF;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            cnt_q         <= cnt_d;
            shadow_q      <= shadow_d;
            active_q      <= active_d;
            pending_q     <= pending_d;
            frame_start_q <= frame_start_d;
            bcd_out_q     <= bcd_out_d;
            digit_en_n_q  <= digit_en_n_d;
        end
    end

    assign bcd_out     = bcd_out_q;
    assign digit_en_n  = digit_en_n_q;
    assign pending     = pending_q;
    assign frame_start = frame_start_q;

endmodule
